// File: rtl/cc_serializer_if.sv
// Signal bundle between the read-response serializer, its line FIFO and the R channel.
// The master side is the serializer; the slave side is the FIFO/interconnect environment.
interface cc_serializer_if #(
   parameter int DATA_WIDTH = 64,
   parameter int LINE_WIDTH = 512
);
   logic                  fifo_empty_i;
   logic [LINE_WIDTH-1:0] fifo_rdata_i;
   logic [5:0]            fifo_offset_i;
   logic                  fifo_rden_o;
   logic [DATA_WIDTH-1:0] inct_rdata_o;
   logic                  inct_rvalid_o;
   logic                  inct_rlast_o;
   logic                  inct_rready_i;

   modport master (
      input  fifo_empty_i, fifo_rdata_i, fifo_offset_i, inct_rready_i,
      output fifo_rden_o, inct_rdata_o, inct_rvalid_o, inct_rlast_o
   );

   modport slave (
      output fifo_empty_i, fifo_rdata_i, fifo_offset_i, inct_rready_i,
      input  fifo_rden_o, inct_rdata_o, inct_rvalid_o, inct_rlast_o
   );
endinterface

// File: rtl/cc_serializer.sv
// Pops one cache line from a fall-through FIFO and returns it as eight R-channel beats,
// critical word first, wrapping within the line, with rlast on the eighth beat.
module cc_serializer #(
   parameter int DATA_WIDTH = 64,
   parameter int LINE_WIDTH = 512
) (
   input  logic            clk,
   input  logic            rst,
   cc_serializer_if.master bus
);
   typedef enum logic {IDLE, SEND} state_e;

   state_e                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [2:0]            start_q, start_d;
   logic [LINE_WIDTH-1:0] line_q, line_d;
   logic                  pop;
   logic [2:0]            word_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         start_q <= 3'd0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         start_q <= start_d;
         line_q  <= line_d;
      end
   end

   // A pop is allowed from IDLE or on the last-beat handshake, which keeps lines gap-free.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      start_d = start_q;
      line_d  = line_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!bus.fifo_empty_i) pop = 1'b1;
         end
         SEND: begin
            if (bus.inct_rready_i) begin
               if (cnt_q == 3'd7) begin
                  cnt_d = 3'd0;
                  if (!bus.fifo_empty_i) pop = 1'b1;
                  else state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (pop) begin
         line_d  = bus.fifo_rdata_i;
         start_d = bus.fifo_offset_i[5:3];
         cnt_d   = 3'd0;
         state_d = SEND;
      end
   end

   // 3-bit add wraps naturally, giving the critical-word-first order.
   assign word_idx = start_q + cnt_q;

   always_comb begin
      bus.inct_rdata_o = '0;
      if (state_q == SEND) bus.inct_rdata_o = line_q[int'(word_idx)*DATA_WIDTH +: DATA_WIDTH];
   end

   assign bus.inct_rvalid_o = (state_q == SEND);
   assign bus.inct_rlast_o  = (state_q == SEND) && (cnt_q == 3'd7);
   // Reset blocks popping so no line is lost while the serializer is held.
   assign bus.fifo_rden_o   = pop && !rst;
endmodule

// File: tb/tb_cc_serializer.sv
// Randomized bench for cc_serializer: a queue-based FIFO model feeds lines and a
// line-to-beats reference model predicts every R-channel beat.
module tb_cc_serializer;
   typedef struct {
      logic [511:0] line;
      logic [5:0]   off;
   } ent_t;
   typedef struct {
      logic [63:0] data;
      logic        last;
      int          cyc;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cc_serializer_if #(.DATA_WIDTH(64), .LINE_WIDTH(512)) bus ();
   cc_serializer #(.DATA_WIDTH(64), .LINE_WIDTH(512)) dut (.clk(clk), .rst(rst), .bus(bus));

   ent_t  fq[$];
   beat_t exp_q[$];
   beat_t obs[$];
   int    pop_log[$];
   bit    pend_pop = 1'b0;
   int    cyc_n = 0;
   int    n_vec = 0;
   int    n_err = 0;

   logic        s_rvalid, s_rlast, s_rden;
   logic [63:0] s_rdata;

   initial begin
      bus.fifo_empty_i  = 1'b1;
      bus.fifo_rdata_i  = '0;
      bus.fifo_offset_i = '0;
      bus.inct_rready_i = 1'b0;
   end

   // Beat k of a line is word ((offset/8) + k) mod 8; the last flag marks k == 7.
   function automatic void model_push(input ent_t e);
      int st, idx;
      st = int'(e.off) / 8;
      for (int k = 0; k < 8; k++) begin
         idx = (st + k) % 8;
         exp_q.push_back(beat_t'{e.line[64*idx +: 64], (k == 7), 0});
      end
   endfunction

   function automatic ent_t rand_line(input logic [5:0] off);
      ent_t e;
      for (int i = 0; i < 16; i++) e.line[32*i +: 32] = $urandom;
      e.off = off;
      return e;
   endfunction

   function automatic ent_t count_line(input logic [5:0] off);
      ent_t e;
      for (int i = 0; i < 8; i++) e.line[64*i +: 64] = 64'h1111_0000_0000_0000 | 64'(i);
      e.off = off;
      return e;
   endfunction

   // One clock: drive at the falling edge, sample shortly before the rising edge.
   task automatic cyc(input logic rr, input logic rs);
      ent_t tmp;
      @(negedge clk);
      if (pend_pop) begin
         if (fq.size() > 0) tmp = fq.pop_front();
         pend_pop = 1'b0;
      end
      rst = rs;
      bus.inct_rready_i = rr;
      if (fq.size() == 0) begin
         bus.fifo_empty_i  = 1'b1;
         bus.fifo_rdata_i  = '0;
         bus.fifo_offset_i = '0;
      end else begin
         bus.fifo_empty_i  = 1'b0;
         bus.fifo_rdata_i  = fq[0].line;
         bus.fifo_offset_i = fq[0].off;
      end
      #2;
      s_rvalid = bus.inct_rvalid_o;
      s_rlast  = bus.inct_rlast_o;
      s_rdata  = bus.inct_rdata_o;
      s_rden   = bus.fifo_rden_o;
      if (s_rden) begin
         pend_pop = 1'b1;
         pop_log.push_back(cyc_n);
      end
      if (s_rvalid && rr && !rs) obs.push_back(beat_t'{s_rdata, s_rlast, cyc_n});
      cyc_n++;
   endtask

   task automatic run_beats(input int n, input int budget, input bit rnd);
      for (int i = 0; i < budget && obs.size() < n; i++)
         cyc(rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
   endtask

   task automatic start_test();
      obs.delete();
      exp_q.delete();
      pop_log.delete();
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
      n_vec++; if (s_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got %b want 0", s_rvalid); end
      n_vec++; if (s_rlast !== 1'b0) begin n_err++; $display("FAIL reset_rlast got %b want 0", s_rlast); end
      n_vec++; if (s_rdata !== 64'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", s_rdata); end
      n_vec++; if (s_rden !== 1'b0) begin n_err++; $display("FAIL reset_rden got %b want 0", s_rden); end
      cyc(1'b1, 1'b0);
      n_vec++; if (s_rvalid !== 1'b0) begin n_err++; $display("FAIL idle_rvalid got %b want 0", s_rvalid); end
   endtask

   task automatic test_offset0();
      ent_t e;
      start_test();
      e = count_line(6'h00);
      fq.push_back(e); model_push(e);
      run_beats(8, 40, 1'b0);
      n_vec++; if (obs.size() != 8) begin n_err++; $display("FAIL off0_beats got %0d want 8", obs.size()); end
      for (int i = 0; i < obs.size() && i < 8; i++) begin
         n_vec++;
         if (obs[i].data !== (64'h1111_0000_0000_0000 | 64'(i)) || obs[i].last !== exp_q[i].last) begin
            n_err++; $display("FAIL off0_beat%0d got %h/%b want %h/%b", i, obs[i].data, obs[i].last,
                              64'h1111_0000_0000_0000 | 64'(i), exp_q[i].last);
         end
      end
      n_vec++; if (pop_log.size() != 1) begin n_err++; $display("FAIL off0_pops got %0d want 1", pop_log.size()); end
      if (pop_log.size() > 0 && obs.size() > 0) begin
         n_vec++;
         if (obs[0].cyc != pop_log[0] + 1) begin
            n_err++; $display("FAIL off0_latency got cycle %0d want %0d", obs[0].cyc, pop_log[0] + 1);
         end
      end
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
   endtask

   task automatic test_wrap();
      ent_t e;
      int ord[8];
      ord = '{5, 6, 7, 0, 1, 2, 3, 4};
      start_test();
      e = count_line(6'h2B);
      fq.push_back(e); model_push(e);
      run_beats(8, 40, 1'b0);
      n_vec++; if (obs.size() != 8) begin n_err++; $display("FAIL wrap_beats got %0d want 8", obs.size()); end
      for (int i = 0; i < obs.size() && i < 8; i++) begin
         n_vec++;
         if (obs[i].data !== (64'h1111_0000_0000_0000 | 64'(ord[i])) || obs[i].last !== (i == 7)) begin
            n_err++; $display("FAIL wrap_beat%0d got %h/%b want word %0d", i, obs[i].data, obs[i].last, ord[i]);
         end
      end
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
   endtask

   task automatic test_backpressure();
      ent_t e;
      logic p_valid, p_last, p_rr, rr;
      logic [63:0] p_data;
      int stall_n;
      start_test();
      e = count_line(6'h08);
      fq.push_back(e); model_push(e);
      p_valid = 1'b0; p_rr = 1'b1; p_last = 1'b0; p_data = '0; stall_n = 0;
      for (int i = 0; i < 200 && obs.size() < 8; i++) begin
         if (obs.size() == 6 && stall_n < 5) begin
            rr = 1'b0; stall_n++;
         end else begin
            rr = 1'($urandom_range(0, 1));
         end
         cyc(rr, 1'b0);
         if (p_valid && !p_rr) begin
            n_vec++;
            if (s_rvalid !== 1'b1 || s_rdata !== p_data || s_rlast !== p_last) begin
               n_err++; $display("FAIL bp_stable got %b/%h/%b want 1/%h/%b", s_rvalid, s_rdata, s_rlast, p_data, p_last);
            end
         end
         p_valid = s_rvalid; p_data = s_rdata; p_last = s_rlast; p_rr = rr;
      end
      n_vec++; if (obs.size() != 8) begin n_err++; $display("FAIL bp_handshakes got %0d want 8", obs.size()); end
      for (int i = 0; i < obs.size() && i < 8; i++) begin
         n_vec++;
         if (obs[i].data !== (64'h1111_0000_0000_0000 | 64'((i + 1) % 8)) || obs[i].last !== (i == 7)) begin
            n_err++; $display("FAIL bp_beat%0d got %h/%b want word %0d", i, obs[i].data, obs[i].last, (i + 1) % 8);
         end
      end
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      ent_t e1, e2;
      start_test();
      e1 = rand_line(6'h00); e2 = rand_line(6'h38);
      fq.push_back(e1); model_push(e1);
      fq.push_back(e2); model_push(e2);
      run_beats(16, 60, 1'b0);
      n_vec++; if (obs.size() != 16) begin n_err++; $display("FAIL b2b_beats got %0d want 16", obs.size()); end
      for (int i = 0; i < obs.size() && i < 16; i++) begin
         n_vec++;
         if (obs[i].data !== exp_q[i].data || obs[i].last !== exp_q[i].last || obs[i].cyc != obs[0].cyc + i) begin
            n_err++; $display("FAIL b2b_beat%0d got %h/%b@%0d want %h/%b@%0d", i, obs[i].data, obs[i].last,
                              obs[i].cyc, exp_q[i].data, exp_q[i].last, obs[0].cyc + i);
         end
      end
      n_vec++; if (pop_log.size() != 2) begin n_err++; $display("FAIL b2b_pops got %0d want 2", pop_log.size()); end
      if (pop_log.size() == 2 && obs.size() == 16) begin
         n_vec++;
         if (pop_log[1] != obs[7].cyc) begin
            n_err++; $display("FAIL b2b_pop2 got cycle %0d want %0d", pop_log[1], obs[7].cyc);
         end
         n_vec++;
         if (obs[8].data !== e2.line[448 +: 64]) begin
            n_err++; $display("FAIL b2b_start7 got %h want %h", obs[8].data, e2.line[448 +: 64]);
         end
      end
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
   endtask

   task automatic test_empty();
      int bad;
      start_test();
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1'($urandom_range(0, 1)), 1'b0);
         n_vec++;
         if (s_rden !== 1'b0 || s_rvalid !== 1'b0) begin
            n_err++; $display("FAIL empty_cycle%0d got rden=%b rvalid=%b want 0/0", i, s_rden, s_rvalid);
         end
      end
   endtask

   task automatic test_reset_mid();
      ent_t e1, e2;
      start_test();
      e1 = rand_line(6'(($urandom_range(0, 7)) * 8));
      fq.push_back(e1); model_push(e1);
      run_beats(3, 30, 1'b0);
      n_vec++; if (obs.size() != 3) begin n_err++; $display("FAIL rstmid_pre got %0d want 3", obs.size()); end
      cyc(1'b1, 1'b1);
      n_vec++;
      if (s_rvalid !== 1'b1 || s_rdata !== exp_q[3].data) begin
         n_err++; $display("FAIL rstmid_beat3 got %b/%h want 1/%h", s_rvalid, s_rdata, exp_q[3].data);
      end
      e2 = rand_line(6'(($urandom_range(0, 7)) * 8 + $urandom_range(0, 7)));
      fq.push_back(e2);
      cyc(1'b1, 1'b1);
      n_vec++;
      if (s_rvalid !== 1'b0 || s_rlast !== 1'b0 || s_rdata !== 64'h0 || s_rden !== 1'b0) begin
         n_err++; $display("FAIL rstmid_outs got v=%b l=%b d=%h rden=%b want all 0", s_rvalid, s_rlast, s_rdata, s_rden);
      end
      start_test();
      model_push(e2);
      run_beats(8, 40, 1'b1);
      n_vec++; if (obs.size() != 8) begin n_err++; $display("FAIL rstmid_beats got %0d want 8", obs.size()); end
      for (int i = 0; i < obs.size() && i < 8; i++) begin
         n_vec++;
         if (obs[i].data !== exp_q[i].data || obs[i].last !== exp_q[i].last) begin
            n_err++; $display("FAIL rstmid_beat%0d got %h/%b want %h/%b", i, obs[i].data, obs[i].last,
                              exp_q[i].data, exp_q[i].last);
         end
      end
      n_vec++; if (pop_log.size() != 1) begin n_err++; $display("FAIL rstmid_pops got %0d want 1", pop_log.size()); end
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_offset0();
      test_wrap();
      test_backpressure();
      test_back_to_back();
      test_empty();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
